fifo_drain_ctl: RTL and testbench

- Consumer-side controller for the byte replay FIFO. It drives the FIFO's read, replay and erase controls and absorbs the FIFO's one-cycle registered read latency.
- It streams each byte to a downstream transmitter, such as the UART TX, over a valid/ready handshake.
- It sits between the FIFO and the TX, and is commanded by the top-level button/command logic: drain, replay-then-drain, or erase.

---
 rtl/fifo_drain_ctl_pkg.sv | 23 ++
 rtl/fifo_drain_gap_timer.sv | 32 +++
 rtl/fifo_drain_ctl.sv | 131 +++++++++++++
 tb/tb_fifo_drain_ctl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_ctl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_drain_ctl_pkg : shared state encoding and width defaults
// Revision: 1.0
// ------------------------------------------------------------------
package fifo_drain_ctl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 9;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REWIND  = 3'd1,
      SETTLE  = 3'd2,
      FETCH   = 3'd3,
      WAIT    = 3'd4,
      PRESENT = 3'd5,
      GAPWAIT = 3'd6,
      ERASE   = 3'd7
   } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_drain_gap_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_drain_gap_timer : loadable down-counter with zero flag
// Revision: 1.0
// ------------------------------------------------------------------
module fifo_drain_gap_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             resetB,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/fifo_drain_ctl.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_drain_ctl : drains the byte replay FIFO into a valid/ready TX
// Revision: 1.0
// ------------------------------------------------------------------
module fifo_drain_ctl
   import fifo_drain_ctl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int GAP    = 0
) (
   input  logic              clk,
   input  logic              resetB,
   input  logic              start,
   input  logic              replay_start,
   input  logic              erase_req,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              fifo_emptyB,
   output logic              fifo_read,
   output logic              fifo_replay,
   output logic              fifo_erase,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  byte_count
);

   localparam bit HAS_GAP = (GAP > 0);

   drain_state_t state;
   drain_state_t state_next;
   logic         done_next;
   logic         accept;
   logic         gap_zero;

   assign accept = (state == PRESENT) && tx_valid && tx_ready;

   generate
      if (GAP > 0) begin : g_gap
         localparam int GW = $clog2(GAP + 1);
         fifo_drain_gap_timer #(
            .WIDTH(GW)
         ) u_gap_timer (
            .clk        (clk),
            .resetB     (resetB),
            .load       (accept),
            .load_value (GW'(GAP - 1)),
            .dec        (state == GAPWAIT),
            .zero       (gap_zero)
         );
      end else begin : g_no_gap
         assign gap_zero = 1'b1;
      end
   endgenerate

   // FETCH carries a read only if the strobe was registered on entry,
   // so the empty decision is taken on the edge that enters FETCH.
   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (replay_start) begin
               state_next = REWIND;
            end else if (start) begin
               state_next = FETCH;
            end else if (erase_req) begin
               state_next = ERASE;
            end
         end
         REWIND:  state_next = SETTLE;
         SETTLE:  state_next = FETCH;
         FETCH: begin
            if (fifo_read) begin
               state_next = WAIT;
            end else begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         WAIT:    state_next = PRESENT;
         PRESENT: begin
            if (accept) begin
               state_next = HAS_GAP ? GAPWAIT : FETCH;
            end
         end
         GAPWAIT: begin
            if (gap_zero) begin
               state_next = FETCH;
            end
         end
         ERASE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         state       <= IDLE;
         fifo_read   <= 1'b0;
         fifo_replay <= 1'b0;
         fifo_erase  <= 1'b0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         byte_count  <= '0;
      end else begin
         state       <= state_next;
         fifo_read   <= (state_next == FETCH) && fifo_emptyB;
         fifo_replay <= (state_next == REWIND);
         fifo_erase  <= (state_next == ERASE);
         tx_valid    <= (state_next == PRESENT);
         busy        <= (state_next != IDLE);
         done        <= done_next;
         if (state == WAIT) begin
            tx_data <= fifo_rdata;
         end
         if ((state == IDLE) && (start || replay_start)) begin
            byte_count <= '0;
         end else if (accept && (byte_count != '1)) begin
            byte_count <= byte_count + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_ctl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fifo_drain_ctl : directed bench with a behavioural replay FIFO
// Revision: 1.0
// ------------------------------------------------------------------
module tb_fifo_drain_ctl;

   logic       clk = 1'b0;
   logic       resetB;
   logic       start [2];
   logic       rstart [2];
   logic       ereq [2];
   logic       txr [2];
   logic       wr_en [2];
   logic [7:0] wr_data;

   logic       rd [2];
   logic       rep [2];
   logic       er [2];
   logic       txv [2];
   logic       busy [2];
   logic       done [2];
   logic [7:0] txd [2];
   logic [8:0] cnt [2];
   logic       emptyB [2];

   logic [7:0] mem [2][16];
   logic [3:0] wp [2] = '{default: 4'd0};
   logic [3:0] rp [2] = '{default: 4'd0};
   logic [7:0] rdata [2] = '{default: 8'd0};

   always #5 clk = ~clk;

   fifo_drain_ctl #(.DATA_W(8), .CNT_W(9), .GAP(0)) dut (
      .clk(clk), .resetB(resetB), .start(start[0]), .replay_start(rstart[0]),
      .erase_req(ereq[0]), .fifo_rdata(rdata[0]), .fifo_emptyB(emptyB[0]),
      .fifo_read(rd[0]), .fifo_replay(rep[0]), .fifo_erase(er[0]),
      .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(txr[0]),
      .busy(busy[0]), .done(done[0]), .byte_count(cnt[0])
   );

   fifo_drain_ctl #(.DATA_W(8), .CNT_W(9), .GAP(3)) dut_gap (
      .clk(clk), .resetB(resetB), .start(start[1]), .replay_start(rstart[1]),
      .erase_req(ereq[1]), .fifo_rdata(rdata[1]), .fifo_emptyB(emptyB[1]),
      .fifo_read(rd[1]), .fifo_replay(rep[1]), .fifo_erase(er[1]),
      .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(txr[1]),
      .busy(busy[1]), .done(done[1]), .byte_count(cnt[1])
   );

   // Replay FIFO model: registered read data, rewind to entry 0, erase clears.
   assign emptyB[0] = (rp[0] != wp[0]);
   assign emptyB[1] = (rp[1] != wp[1]);

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (wr_en[k]) begin
            mem[k][wp[k]] <= wr_data;
            wp[k]         <= wp[k] + 4'd1;
         end
         if (er[k]) begin
            wp[k] <= 4'd0;
            rp[k] <= 4'd0;
         end else if (rep[k]) begin
            rp[k] <= 4'd0;
         end else if (rd[k]) begin
            rdata[k] <= mem[k][rp[k]];
            rp[k]    <= rp[k] + 4'd1;
         end
      end
   end

   int         cyc = 0;
   int         n_rd = 0, n_rep = 0, n_er = 0, n_done = 0, n_txv = 0, n_viol = 0;
   int         n_stall = 0, n_stall_bad = 0;
   int         acc0 = 0, delta0 = 0;
   int         acc1 = 0, n_gaps = 0, gap_bad = 0;
   bit         pend1 = 1'b0;
   logic [7:0] got [$];

   always @(negedge clk) begin
      if (rd[0])   n_rd++;
      if (rep[0])  n_rep++;
      if (er[0])   n_er++;
      if (done[0]) n_done++;
      if (txv[0])  n_txv++;
      if ((rd[0] && !emptyB[0]) || (rd[0] && rep[0]) || (rd[0] && txv[0])) n_viol++;
      if (txv[0] && !txr[0]) begin
         n_stall++;
         if (txd[0] != 8'h48) n_stall_bad++;
      end
      if (txv[0] && txr[0]) begin
         got.push_back(txd[0]);
         delta0 = cyc - acc0;
         acc0   = cyc;
      end
      if (rd[1] && pend1) begin
         if (cyc - acc1 - 1 != 3) gap_bad++;
         n_gaps++;
         pend1 = 1'b0;
      end
      if (txv[1] && txr[1]) begin
         acc1  = cyc;
         pend1 = 1'b1;
      end
      cyc++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int k, input logic [7:0] b);
      wr_en[k] = 1'b1;
      wr_data  = b;
      tick();
      wr_en[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input string tag);
      for (int t = 0; t < 80 && !done[k]; t++) tick();
      check_val(tag, 32'(done[k]), 32'd1);
      tick();
   endtask

   task automatic wait_valid(input int k, input string tag);
      for (int t = 0; t < 40 && !txv[k]; t++) tick();
      check_val(tag, 32'(txv[k]), 32'd1);
   endtask

   int b_rd, b_rep, b_er, b_done, b_txv, b_got, b_stall, b_viol;

   task automatic mark();
      b_rd = n_rd; b_rep = n_rep; b_er = n_er; b_done = n_done;
      b_txv = n_txv; b_got = got.size(); b_stall = n_stall;
   endtask

   initial begin
      resetB  = 1'b0;
      wr_data = 8'h00;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; rstart[k] = 1'b0; ereq[k] = 1'b0;
         txr[k] = 1'b1; wr_en[k] = 1'b0;
      end
      repeat (3) tick();
      check_val("rst_outputs", {rd[0], rep[0], er[0], txv[0], busy[0], done[0]}, 32'd0);
      check_val("rst_count", 32'(cnt[0]), 32'd0);
      check_val("rst_txdata", 32'(txd[0]), 32'd0);
      resetB = 1'b1;
      tick();
      b_viol = n_viol;

      // basic drain of "HI"
      push(0, 8'h48);
      push(0, 8'h49);
      mark();
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      wait_done(0, "drain_done");
      check_val("drain_b0", 32'(got[b_got]), 32'h48);
      check_val("drain_b1", 32'(got[b_got+1]), 32'h49);
      check_val("drain_nbytes", 32'(got.size() - b_got), 32'd2);
      check_val("drain_valid_cycles", 32'(n_txv - b_txv), 32'd2);
      check_val("drain_reads", 32'(n_rd - b_rd), 32'd2);
      check_val("drain_done_pulses", 32'(n_done - b_done), 32'd1);
      check_val("drain_count", 32'(cnt[0]), 32'd2);
      check_val("drain_rate", 32'(delta0), 32'd3);
      check_val("drain_idle", 32'(busy[0]), 32'd0);

      // replay re-sends the same bytes
      mark();
      rstart[0] = 1'b1; tick(); rstart[0] = 1'b0;
      wait_done(0, "replay_done");
      check_val("replay_strobe", 32'(n_rep - b_rep), 32'd1);
      check_val("replay_b0", 32'(got[b_got]), 32'h48);
      check_val("replay_b1", 32'(got[b_got+1]), 32'h49);
      check_val("replay_count", 32'(cnt[0]), 32'd2);

      // back-pressure on the first byte
      push(0, 8'h48);
      push(0, 8'h49);
      mark();
      txr[0] = 1'b0;
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      wait_valid(0, "stall_valid");
      check_val("stall_data", 32'(txd[0]), 32'h48);
      b_stall = n_stall;
      repeat (5) tick();
      check_val("stall_cycles", 32'(n_stall - b_stall), 32'd5);
      check_val("stall_held", 32'(n_stall_bad), 32'd0);
      check_val("stall_reads", 32'(n_rd - b_rd), 32'd1);
      txr[0] = 1'b1;
      wait_done(0, "stall_done");
      check_val("stall_b1", 32'(got[b_got+1]), 32'h49);
      check_val("stall_count", 32'(cnt[0]), 32'd2);

      // empty FIFO
      mark();
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      for (int t = 0; t < 2 && !done[0]; t++) tick();
      check_val("empty_done", 32'(done[0]), 32'd1);
      tick();
      check_val("empty_reads", 32'(n_rd - b_rd), 32'd0);
      check_val("empty_count", 32'(cnt[0]), 32'd0);

      // start+replay coincide; erase while busy is dropped
      mark();
      start[0] = 1'b1; rstart[0] = 1'b1; tick();
      start[0] = 1'b0; rstart[0] = 1'b0;
      tick(); tick();
      ereq[0] = 1'b1; tick(); ereq[0] = 1'b0;
      wait_done(0, "combo_done");
      check_val("combo_replay", 32'(n_rep - b_rep), 32'd1);
      check_val("combo_count", 32'(cnt[0]), 32'd4);
      check_val("busy_erase_ignored", 32'(n_er - b_er), 32'd0);

      // erase in IDLE
      push(0, 8'h55);
      check_val("erase_pre_data", 32'(emptyB[0]), 32'd1);
      mark();
      ereq[0] = 1'b1; tick(); ereq[0] = 1'b0;
      repeat (3) tick();
      check_val("erase_pulses", 32'(n_er - b_er), 32'd1);
      check_val("erase_empty", 32'(emptyB[0]), 32'd0);
      check_val("erase_no_done", 32'(n_done - b_done), 32'd0);

      // asynchronous reset while presenting
      push(0, 8'h41);
      push(0, 8'h42);
      txr[0] = 1'b1;
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      wait_valid(0, "arst_first");
      tick();
      txr[0] = 1'b0;
      wait_valid(0, "arst_second");
      check_val("arst_pre_count", 32'(cnt[0]), 32'd1);
      #2 resetB = 1'b0;
      #1;
      check_val("arst_valid", 32'(txv[0]), 32'd0);
      check_val("arst_busy", 32'(busy[0]), 32'd0);
      check_val("arst_count", 32'(cnt[0]), 32'd0);
      tick(); tick();
      resetB = 1'b1;
      txr[0] = 1'b1;
      mark();
      repeat (10) tick();
      check_val("arst_quiet", 32'((n_rd - b_rd) + (n_rep - b_rep) + (n_er - b_er)), 32'd0);
      check_val("arst_idle", 32'(busy[0]), 32'd0);

      // GAP=3 instance
      push(1, 8'h10);
      push(1, 8'h11);
      push(1, 8'h12);
      start[1] = 1'b1; tick(); start[1] = 1'b0;
      wait_done(1, "gap_done");
      check_val("gap_count", 32'(cnt[1]), 32'd3);
      check_val("gap_measured", 32'(n_gaps), 32'd2);
      check_val("gap_length", 32'(gap_bad), 32'd0);

      check_val("invariants", 32'(n_viol - b_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
